// File: rtl/axi_mem_responder_if.sv
// AXI4 bundle between the PageRank engine (master) and axi_mem_responder (slave).
interface axi_mem_responder_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 16
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arvalid, input  arready,
    input  rid, rdata, rresp, rlast, rvalid,     output rready,
    output awid, awaddr, awlen, awsize, awvalid, input  awready,
    output wid, wdata, wstrb, wlast, wvalid,     input  wready,
    input  bid, bresp, bvalid,                   output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,     input  rready,
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid,     output wready,
    output bid, bresp, bvalid,                   input  bready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI slave memory model: independent INCR read/write FSMs over one word array.
// Optional AXI_MEM_RAND_STALL_EN adds LFSR-driven pseudo-random backpressure.
module axi_mem_responder #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  axi_mem_responder_if.slave axi
);
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;
  localparam logic [1:0] W_IDLE  = 2'b00;
  localparam logic [1:0] W_DATA  = 2'b01;
  localparam logic [1:0] W_RESP  = 2'b10;

  logic [DATA_W-1:0] mem_q [DEPTH];

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return idx[IDX_W-1:MEM_AW] == '0;
  endfunction

  logic stall_ar, stall_aw, stall_w, stall_r;
`ifdef AXI_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
  assign stall_ar = lfsr_q[0];
  assign stall_aw = lfsr_q[1];
  assign stall_w  = lfsr_q[2];
  assign stall_r  = lfsr_q[3];
`else
  assign stall_ar = 1'b0;
  assign stall_aw = 1'b0;
  assign stall_w  = 1'b0;
  assign stall_r  = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{axi.wid, axi.arsize, axi.awsize, axi.araddr[OFF_W-1:0], axi.awaddr[OFF_W-1:0]};

  // ---------------- read channel ----------------
  logic [0:0]        rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d, ld_idx;
  logic [7:0]        rcnt_q, rcnt_d, rlen_q, rlen_d, ld_cnt, ld_len;
  logic              ar_hs, r_hs, load;

  assign ar_hs = axi.arvalid & arready_q & ~stall_ar;
  assign r_hs  = rvalid_q & axi.rready;

  // One load path serves both the first beat (from the AR request) and later beats.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    ridx_d    = ridx_q;
    rcnt_d    = rcnt_q;
    rlen_d    = rlen_q;
    ld_idx    = ridx_q;
    ld_cnt    = rcnt_q;
    ld_len    = rlen_q;
    load      = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rstate_d  = R_BURST;
          arready_d = 1'b0;
          rid_d     = axi.arid;
          rlen_d    = axi.arlen;
          ridx_d    = axi.araddr[ADDR_W-1:OFF_W];
          rcnt_d    = '0;
          ld_idx    = axi.araddr[ADDR_W-1:OFF_W];
          ld_cnt    = '0;
          ld_len    = axi.arlen;
          load      = ~stall_r;
        end
      end
      default: begin
        if (r_hs && rlast_q) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
        end else if (!rvalid_q || r_hs) begin
          if (r_hs) rvalid_d = 1'b0;
          load = ~stall_r;
        end
      end
    endcase
    if (load) begin
      rvalid_d = 1'b1;
      rdata_d  = in_range(ld_idx) ? mem_q[ld_idx[MEM_AW-1:0]] : '0;
      rresp_d  = in_range(ld_idx) ? RESP_OKAY : RESP_DECERR;
      rlast_d  = (ld_cnt == ld_len);
      ridx_d   = ld_idx + IDX_W'(1);
      rcnt_d   = ld_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      ridx_q    <= '0;
      rcnt_q    <= '0;
      rlen_q    <= '0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      ridx_q    <= ridx_d;
      rcnt_q    <= rcnt_d;
      rlen_q    <= rlen_d;
    end
  end

  // ---------------- write channel ----------------
  logic [1:0]       wstate_q, wstate_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, werr_q, werr_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wcnt_q, wcnt_d, wlen_q, wlen_d;
  logic             aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs  = axi.awvalid & awready_q & ~stall_aw;
  assign w_hs   = axi.wvalid & wready_q & ~stall_w;
  assign b_hs   = bvalid_q & axi.bready;
  assign mem_we = w_hs & in_range(widx_q);

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    wlen_d    = wlen_q;
    werr_d    = werr_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = axi.awid;
          widx_d    = axi.awaddr[ADDR_W-1:OFF_W];
          wcnt_d    = '0;
          wlen_d    = axi.awlen;
          werr_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          widx_d = widx_q + IDX_W'(1);
          wcnt_d = wcnt_q + 8'd1;
          werr_d = werr_q | ~in_range(widx_q);
          if (axi.wlast || wcnt_q == wlen_q) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q | ~in_range(widx_q)) ? RESP_DECERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      bid_q     <= '0;
      widx_q    <= '0;
      wcnt_q    <= '0;
      wlen_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      werr_q    <= werr_d;
    end
  end

  // Array is deliberately not reset; same-cycle read of a written word sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (axi.wstrb[b]) mem_q[widx_q[MEM_AW-1:0]][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  assign axi.arready = arready_q & ~stall_ar;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.awready = awready_q & ~stall_aw;
  assign axi.wready  = wready_q & ~stall_w;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.bvalid  = bvalid_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default build, no random stalls).
module tb_axi_mem_responder;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ID_W   = 16;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic [DATA_W-1:0] model [DEPTH];

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] beat_data(input logic [DATA_W-1:0] seed, input logic [7:0] i);
    return seed ^ {BYTES{i}};
  endfunction

  task automatic do_write(input string t, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                          input logic [7:0] len, input int unsigned nbeats, input logic [BYTES-1:0] strb,
                          input logic [DATA_W-1:0] seed, output logic [1:0] resp);
    logic rdy;
    int unsigned n;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] d;
    idx = addr >> OFF_W;
    axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd6; axi.awvalid = 1'b1;
    n = 0;
    do begin rdy = axi.awready; tick(); n++; end while (!rdy && n < 50);
    axi.awvalid = 1'b0;
    check({t, "_aw_hs"}, rdy, 1'b1);
    for (int unsigned i = 0; i < nbeats; i++) begin
      d = beat_data(seed, 8'(i));
      axi.wdata = d; axi.wstrb = strb; axi.wid = id; axi.wlast = (i == nbeats - 1); axi.wvalid = 1'b1;
      n = 0;
      do begin rdy = axi.wready; tick(); n++; end while (!rdy && n < 50);
      check({t, "_w_hs"}, rdy, 1'b1);
      if (rdy && idx < 64'(DEPTH))
        for (int unsigned b = 0; b < BYTES; b++)
          if (strb[b]) model[idx[9:0]][b*8 +: 8] = d[b*8 +: 8];
      idx++;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    check({t, "_bvalid_next"}, axi.bvalid, 1'b1);
    check({t, "_wready_low"}, axi.wready, 1'b0);
    check({t, "_bid"}, axi.bid, id);
    resp = axi.bresp;
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    check({t, "_bvalid_clear"}, axi.bvalid, 1'b0);
  endtask

  task automatic do_read(input string t, input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                         input logic [7:0] len, input logic toggle);
    logic rdy, hs;
    int unsigned n, beat, cyc;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] exp_d;
    logic [1:0] exp_r;
    idx = addr >> OFF_W;
    axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd6; axi.arvalid = 1'b1;
    n = 0;
    do begin rdy = axi.arready; tick(); n++; end while (!rdy && n < 50);
    axi.arvalid = 1'b0;
    check({t, "_ar_hs"}, rdy, 1'b1);
    check({t, "_rvalid_1cyc"}, axi.rvalid, 1'b1);
    check({t, "_arready_low"}, axi.arready, 1'b0);
    beat = 0; cyc = 0;
    while (beat <= 32'(len) && cyc < 200) begin
      axi.rready = toggle ? cyc[0] : 1'b1;
      if (idx < 64'(DEPTH)) begin exp_d = model[idx[9:0]]; exp_r = 2'b00; end
      else begin exp_d = '0; exp_r = 2'b11; end
      check({t, "_rvalid"}, axi.rvalid, 1'b1);
      check({t, "_rdata"}, axi.rdata, exp_d);
      check({t, "_rresp"}, axi.rresp, exp_r);
      check({t, "_rlast"}, axi.rlast, beat == 32'(len));
      check({t, "_rid"}, axi.rid, id);
      hs = axi.rvalid & axi.rready;
      tick();
      cyc++;
      if (hs) begin beat++; idx++; end
    end
    axi.rready = 1'b0;
    check({t, "_beats"}, beat, 32'(len) + 1);
    check({t, "_rvalid_done"}, axi.rvalid, 1'b0);
    check({t, "_arready_back"}, axi.arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic rdy;
    int unsigned n, beats;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awvalid = 1'b0;
    axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", axi.arready, 1'b0);
    check("rst_awready", axi.awready, 1'b0);
    check("rst_rvalid", axi.rvalid, 1'b0);
    check("rst_wready", axi.wready, 1'b0);
    check("rst_bvalid", axi.bvalid, 1'b0);
    rst = 1'b0;
    check("arready_pre_edge", axi.arready, 1'b0);
    tick();
    check("arready_post_rel", axi.arready, 1'b1);
    check("awready_post_rel", axi.awready, 1'b1);

    // single beat write/read at 0x40
    do_write("t1w", 64'h40, 16'h1234, 8'd0, 1, '1, {16{32'hA5A5_0F0F}}, resp);
    check("t1_bresp", resp, 2'b00);
    do_read("t1r", 64'h40, 16'h4321, 8'd0, 1'b0);

    // 16-beat burst with rready toggling
    do_write("t2w", 64'h1000, 16'h0BEE, 8'd15, 16, '1, {16{32'h1357_9BDF}}, resp);
    check("t2_bresp", resp, 2'b00);
    do_read("t2r", 64'h1000, 16'h0CAF, 8'd15, 1'b1);

    // partial strobe: byte0 cleared, rest 0xFF
    do_write("t3a", 64'h0, 16'h0003, 8'd0, 1, '1, '1, resp);
    do_write("t3b", 64'h0, 16'h0004, 8'd0, 1, 64'h1, '0, resp);
    check("t3_bresp", resp, 2'b00);
    do_read("t3r", 64'h0, 16'h0005, 8'd0, 1'b0);

    // straddle the top of the array
    do_write("t4w", 64'(DEPTH - 1) << OFF_W, 16'h00D4, 8'd1, 2, '1, {16{32'hDEAD_BEEF}}, resp);
    check("t4_bresp", resp, 2'b11);
    do_read("t4r", 64'(DEPTH - 1) << OFF_W, 16'h00D5, 8'd1, 1'b0);

    // early wlast on beat 2 of a 4-beat burst
    do_write("t5w", 64'h2000, 16'h0055, 8'd3, 2, '1, {16{32'h2468_ACE0}}, resp);
    check("t5_bresp", resp, 2'b00);
    axi.wvalid = 1'b1; axi.wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_extra_w", axi.wready, 1'b0);
      tick();
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    do_read("t5r", 64'h2000, 16'h0056, 8'd1, 1'b0);

    // reset in the middle of an 8-beat read
    do_write("t6w", 64'h3000, 16'h0066, 8'd7, 8, '1, {16{32'h0F1E_2D3C}}, resp);
    axi.arid = 16'h0077; axi.araddr = 64'h3000; axi.arlen = 8'd7; axi.arvalid = 1'b1;
    n = 0;
    do begin rdy = axi.arready; tick(); n++; end while (!rdy && n < 50);
    axi.arvalid = 1'b0;
    check("t6_ar_hs", rdy, 1'b1);
    axi.rready = 1'b1;
    beats = 0; n = 0;
    while (beats < 3 && n < 50) begin
      if (axi.rvalid) beats++;
      tick();
      n++;
    end
    check("t6_three_beats", beats, 3);
    rst = 1'b1;
    #1;
    check("t6_rst_rvalid", axi.rvalid, 1'b0);
    check("t6_rst_rlast", axi.rlast, 1'b0);
    check("t6_rst_rdata", axi.rdata, '0);
    check("t6_rst_rid", axi.rid, '0);
    check("t6_rst_arready", axi.arready, 1'b0);
    check("t6_rst_awready", axi.awready, 1'b0);
    axi.rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_stale", axi.rvalid, 1'b0);
    end
    do_read("t6r", 64'h3000, 16'h0088, 8'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
